ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to a keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Implements the request-to-send sequence, 11-frame bit shifting on device-generated clock, ACK check and bus-idle wait.
- Sits beside the existing PS/2 receive path and shares the same two open-drain pins through external tri-state buffers.
- While this block owns the bus, the receive path must ignore traffic. This block's TX_Busy is used for that gating.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks PS2 clock is held low before request; 100 us at 50 MHz.
- SETUP_CYCLES, 50: system clocks data is held low with clock still low, before clock release.
- TIMEOUT_CYCLES, 750000: watchdog limit per transaction, measured from clock release; 15 ms at 50 MHz.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- TX_Start_Sig  input  1  one-cycle request; accepted only when TX_Busy=0
- TX_Data  input  8  byte to send; sampled on the accepted start cycle
- PS2_CLK_Pin_In  input  1  raw PS2 clock pin level
- PS2_Data_Pin_In  input  1  raw PS2 data pin level
- PS2_CLK_OE  output  1  1 = drive PS2 clock low; 0 = release
- PS2_Data_OE  output  1  1 = drive PS2 data low; 0 = release
- TX_Busy  output  1  high from accepted start until return to IDLE
- TX_Done_Sig  output  1  one-cycle pulse, ACK received and bus idle
- TX_Err_Sig  output  1  one-cycle pulse, NAK or timeout

Behaviour:
- Input synchronisation:
  - Both pins pass through 2-FF synchronisers.
  - Falling-edge flag fe = prev_sync & ~sync, one cycle wide.
  - Edges are acted on only in SEND and ACK.
- Reset (any state): all outputs 0, both lines released, state IDLE, counters 0. Mid-transaction reset aborts with no Done/Err pulse.
- IDLE:
  - TX_Start_Sig=1 latches TX_Data.
  - Computes parity = ~^TX_Data (odd parity).
  - Sets CLK_OE=1 and Busy=1, then goes to INHIBIT.
- INHIBIT: CLK_OE=1 for exactly INHIBIT_CYCLES cycles. Then Data_OE=1 and go to RTS.
- RTS: CLK_OE=1 and Data_OE=1 for SETUP_CYCLES cycles. Then CLK_OE=0, bit index=0, start watchdog, go to SEND. Data held low is the start bit.
- SEND: on each fe, drive the next frame bit (Data_OE = ~bit):
  - fe 1-8: TX_Data[0..7], LSB first.
  - fe 9: parity.
  - fe 10: stop bit; Data_OE=0. Go to ACK.
- ACK:
  - On the next fe (11th), sample synced data.
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = NAK: pulse Err, go to IDLE.
- WAIT_IDLE: when both synced lines are 1, pulse Done and go to IDLE.
- TX_Busy:
  - Set in the start-accept cycle.
  - Cleared in the same cycle as the Done/Err pulse.
  - TX_Start_Sig while Busy=1 is ignored and does not affect the latched byte.
- Edge handling:
  - fe is ignored in IDLE, INHIBIT and RTS; the host is driving the clock then.
  - Glitch filtering is not required beyond synchronisation.
- Done and Err are never asserted together. A new start is accepted on the cycle after the pulse.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- Defined:
  - The watchdog counts every cycle in SEND, ACK and WAIT_IDLE.
  - When the count reaches TIMEOUT_CYCLES: release both lines, pulse TX_Err_Sig, go to IDLE.
  - A timeout has priority over a simultaneous fe.
- Not defined:
  - No counter is built.
  - The block waits indefinitely for device clocks. Only RST recovers it.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs:
  - CLK_OE high for 5000 cycles, then Data_OE high.
  - CLK_OE released 50 cycles later.
  - Data_OE sequence over fe 1-9 = 0,1,0,0,1,0,0,0,0 (parity 1), then 0 on fe 10.
  - TX_Done_Sig pulses once.
- Send 0x00: parity=1, Data_OE=1 on fe 1-8 and 0 on fe 9. Device ACK gives a Done pulse.
- Device leaves data high at fe 11 (NAK) -> TX_Err_Sig pulses, no Done, Busy drops that cycle.
- Device never clocks, with PS2_TX_TIMEOUT_EN defined -> Err pulses exactly 750000 cycles after clock release, both OE=0. Without the macro: Busy stays 1 indefinitely.
- Second TX_Start_Sig with TX_Data=0xFF during an 0xED transfer -> ignored, 0xED frame unchanged.
- Assert RST during SEND after fe 4 -> next cycle both OE=0, Busy=0, no Done/Err. A subsequent start sends a complete frame.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shifted out
// on the device clock, ACK check and wait for bus idle.
// Optional macro PS2_TX_TIMEOUT_EN adds a per-transaction watchdog that starts
// when the host releases the clock line.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int SETUP_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TX_Start_Sig,
   input  logic [7:0] TX_Data,
   input  logic       PS2_CLK_Pin_In,
   input  logic       PS2_Data_Pin_In,
   output logic       PS2_CLK_OE,
   output logic       PS2_Data_OE,
   output logic       TX_Busy,
   output logic       TX_Done_Sig,
   output logic       TX_Err_Sig
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       idx, idx_n;
   logic [7:0]       data, data_n;
   logic             par, par_n;
   logic             clk_oe_n, data_oe_n, busy_n, done_n, err_n;

   // Pin synchronisers; the extra clock-stage tap gives the falling-edge flag
   logic clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
   logic fe;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd, wd_n;
`endif

   assign fe = clk_prev & ~clk_sync;

   // Two-stage synchronisers, reset to the idle (high) bus level
   always_ff @(posedge CLK) begin
      if (RST) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= PS2_CLK_Pin_In;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= PS2_Data_Pin_In;
         dat_sync <= dat_meta;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         data        <= '0;
         par         <= 1'b0;
         PS2_CLK_OE  <= 1'b0;
         PS2_Data_OE <= 1'b0;
         TX_Busy     <= 1'b0;
         TX_Done_Sig <= 1'b0;
         TX_Err_Sig  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd          <= '0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         data        <= data_n;
         par         <= par_n;
         PS2_CLK_OE  <= clk_oe_n;
         PS2_Data_OE <= data_oe_n;
         TX_Busy     <= busy_n;
         TX_Done_Sig <= done_n;
         TX_Err_Sig  <= err_n;
`ifdef PS2_TX_TIMEOUT_EN
         wd          <= wd_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      data_n    = data;
      par_n     = par;
      clk_oe_n  = PS2_CLK_OE;
      data_oe_n = PS2_Data_OE;
      busy_n    = TX_Busy;
      done_n    = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            if (TX_Start_Sig) begin
               data_n   = TX_Data;
               par_n    = ~^TX_Data;
               clk_oe_n = 1'b1;
               busy_n   = 1'b1;
               cnt_n    = '0;
               state_n  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
               cnt_n     = '0;
               data_oe_n = 1'b1;
               state_n   = RTS;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RTS: begin
            // data held low here doubles as the start bit once clock is released
            if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
               cnt_n    = '0;
               clk_oe_n = 1'b0;
               idx_n    = '0;
               state_n  = SEND;
            end
         else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         SEND: begin
            if (fe) begin
               idx_n = idx + 4'd1;
               if (idx < 4'd8) begin
                  data_oe_n = ~data[idx[2:0]];
               end else if (idx == 4'd8) begin
                  data_oe_n = ~par;
               end else begin
                  data_oe_n = 1'b0;  // stop bit: release data
                  state_n   = ACK;
               end
            end
         end
         ACK: begin
            if (fe) begin
               if (!dat_sync) begin
                  state_n = WAIT_IDLE;
               end else begin
                  err_n   = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && dat_sync) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // watchdog overrides any edge-driven decision made above
      wd_n = '0;
      if (state == SEND || state == ACK || state == WAIT_IDLE) begin
         if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b1;
            busy_n    = 1'b0;
            state_n   = IDLE;
         end else begin
            wd_n = wd + WD_W'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device and a
// scoreboard of expected Data_OE frames.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int SET = 6;
   localparam int TO  = 3000;
   localparam int HP  = 20;   // device clock half period in system clocks

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       clk_pin, data_pin;
   logic       clk_oe, data_oe, busy, done, err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [9:0] exp_q[$];

   assign clk_pin  = dev_clk & ~clk_oe;
   assign data_pin = dev_dat & ~data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .SETUP_CYCLES  (SET),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .TX_Start_Sig   (start),
      .TX_Data        (tx_data),
      .PS2_CLK_Pin_In (clk_pin),
      .PS2_Data_Pin_In(data_pin),
      .PS2_CLK_OE     (clk_oe),
      .PS2_Data_OE    (data_oe),
      .TX_Busy        (busy),
      .TX_Done_Sig    (done),
      .TX_Err_Sig     (err)
   );

   // Pulse monitor: every Done/Err pulse must be single and coincide with Busy low
   always @(negedge clk) begin
      if (!rst && (done || err)) begin
         if (done) done_cnt++;
         if (err) err_cnt++;
         checks++;
         if (busy !== 1'b0 || (done && err)) begin
            errors++;
            $display("FAIL pulse_busy: busy=%b done=%b err=%b, required busy=0 with one pulse", busy, done, err);
         end
      end
   end

   // Global time bound
   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time bound expired");
   end

   // Issue a start pulse and push the expected Data_OE sequence for fe 1..10
   task automatic send_start(input logic [7:0] d);
      logic [9:0] s;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         s[i] = ~d[i];
         ones += int'(d[i]);
      end
      s[8] = (ones % 2 == 1);  // odd parity bit is 0 when ones is odd -> line driven
      s[9] = 1'b0;
      start   = 1'b1;
      tx_data = d;
      @(negedge clk);
      start = 1'b0;
      exp_q.push_back(s);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_on_start: busy=%b required 1", busy);
      end
   endtask

   // Device model: check RTS timing, give nclk clocks, ACK (or NAK) on clock 11
   task automatic dev_run(input int nclk, input logic nak);
      int n, m, d0, e0;
      logic [9:0] got, want;
      d0 = done_cnt;
      e0 = err_cnt;
      n = 0;
      while (clk_oe === 1'b1 && data_oe === 1'b0 && n < INH + 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != INH) begin
         errors++;
         $display("FAIL inhibit_len: got %0d cycles required %0d", n, INH);
      end
      m = 0;
      while (clk_oe === 1'b1 && data_oe === 1'b1 && m < SET + 20) begin
         m++;
         @(negedge clk);
      end
      checks++;
      if (m != SET) begin
         errors++;
         $display("FAIL setup_len: got %0d cycles required %0d", m, SET);
      end
      checks++;
      if (clk_oe !== 1'b0 || data_oe !== 1'b1) begin
         errors++;
         $display("FAIL start_bit: clk_oe=%b data_oe=%b required 0/1", clk_oe, data_oe);
      end
      got = '0;
      for (int i = 1; i <= nclk; i++) begin
         repeat (HP) @(negedge clk);
         if (i == 11) dev_dat = nak;
         dev_clk = 1'b0;
         repeat (HP) @(negedge clk);
         if (i <= 10) got[i-1] = data_oe;
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: no expected frame queued");
         return;
      end
      want = exp_q.pop_front();
      if (nclk == 11) begin
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL frame: data_oe fe10..1 got %b required %b", got, want);
         end
         n = 0;
         while (done_cnt == d0 && err_cnt == e0 && n < 100) begin
            n++;
            @(negedge clk);
         end
         repeat (5) @(negedge clk);
         checks++;
         if ((done_cnt - d0) != (nak ? 0 : 1) || (err_cnt - e0) != (nak ? 1 : 0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL outcome: done=%0d err=%0d busy=%b, required done=%0d err=%0d busy=0",
                     done_cnt - d0, err_cnt - e0, busy, nak ? 0 : 1, nak ? 1 : 0);
         end
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({clk_oe, data_oe, busy, done, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 00000", {clk_oe, data_oe, busy, done, err});
      end
      start = 1'b0;
      rst   = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({clk_oe, data_oe, busy} !== 3'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b required 000", {clk_oe, data_oe, busy});
      end
   endtask

   task automatic test_send_ed;
      send_start(8'hED);
      dev_run(11, 1'b0);
   endtask

   task automatic test_send_zero;
      send_start(8'h00);
      dev_run(11, 1'b0);
   endtask

   task automatic test_nak;
      send_start(8'h5A);
      dev_run(11, 1'b1);
   endtask

   task automatic test_ignore_start;
      send_start(8'hED);
      fork
         dev_run(11, 1'b0);
         begin
            repeat (INH + SET + 60) @(negedge clk);
            start   = 1'b1;
            tx_data = 8'hFF;
            @(negedge clk);
            start = 1'b0;
         end
      join
   endtask

   task automatic test_reset_mid;
      int d0, e0;
      send_start(8'h3C);
      dev_run(4, 1'b0);
      d0  = done_cnt;
      e0  = err_cnt;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({clk_oe, data_oe, busy} !== 3'b0) begin
         errors++;
         $display("FAIL reset_mid: got %b required 000", {clk_oe, data_oe, busy});
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt != d0 || err_cnt != e0) begin
         errors++;
         $display("FAIL reset_mid_pulse: done+%0d err+%0d required none", done_cnt - d0, err_cnt - e0);
      end
      send_start(8'hA5);
      dev_run(11, 1'b0);
   endtask

   task automatic test_no_clock;
      int n;
      send_start(8'h12);
      void'(exp_q.pop_back());
      n = 0;
      while (clk_oe === 1'b1 && n < INH + SET + 20) begin
         n++;
         @(negedge clk);
      end
`ifdef PS2_TX_TIMEOUT_EN
      n = 0;
      while (err !== 1'b1 && n < TO + 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != TO) begin
         errors++;
         $display("FAIL timeout_len: err after %0d cycles required %0d", n, TO);
      end
      checks++;
      if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin
         errors++;
         $display("FAIL timeout_release: clk_oe=%b data_oe=%b required 0/0", clk_oe, data_oe);
      end
      repeat (3) @(negedge clk);
`else
      repeat (TO + 500) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || clk_oe !== 1'b0 || data_oe !== 1'b1) begin
         errors++;
         $display("FAIL no_clock_hold: busy=%b clk_oe=%b data_oe=%b required 1/0/1", busy, clk_oe, data_oe);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_send_zero();
      test_nak();
      test_ignore_start();
      test_reset_mid();
      test_no_clock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
